regfile_writeback_queue: RTL and testbench

Write-side companion to the 32x32 register file. It collects writeback results from the load unit and the ALU, buffers them in a small in-order queue, and drains one entry per cycle into the register file's single write port. It also gives the operand-read stage a pending-write scoreboard (hit, plus optional forwarded data) so hazards on queued-but-unwritten registers are visible.

---
 rtl/regfile_writeback_queue_if.sv | 63 ++++++
 rtl/regfile_writeback_queue.sv | 118 +++++++++++
 tb/tb_regfile_writeback_queue.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_queue_if.sv
// regfile_writeback_queue_if
//   Bundles the writeback queue's source handshakes, register file write
//   port, operand-read scoreboard queries and occupancy into one interface.
//   master : producer/consumer side (load unit, ALU, register file, read stage)
//   slave  : the queue itself
// Parameters: DEPTH (queue entries), ADDR_W (register address width),
//             DATA_W (register data width).
interface regfile_writeback_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // load source
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  // ALU source
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  // register file write port
  logic              rf_hold;
  logic              rf_write_en;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;
  // pending-write scoreboard
  logic [ADDR_W-1:0] query_addr_a;
  logic [ADDR_W-1:0] query_addr_b;
  logic              pend_hit_a;
  logic              pend_hit_b;
  logic [DATA_W-1:0] fwd_data_a;
  logic [DATA_W-1:0] fwd_data_b;
  // occupancy
  logic [CNT_W-1:0]  wb_count;

  modport master (
    output ld_valid, ld_addr, ld_data,
    input  ld_ready,
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output rf_hold,
    input  rf_write_en, rf_write_addr, rf_write_data,
    output query_addr_a, query_addr_b,
    input  pend_hit_a, pend_hit_b, fwd_data_a, fwd_data_b,
    input  wb_count
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data,
    output ld_ready,
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  rf_hold,
    output rf_write_en, rf_write_addr, rf_write_data,
    input  query_addr_a, query_addr_b,
    output pend_hit_a, pend_hit_b, fwd_data_a, fwd_data_b,
    output wb_count
  );
endinterface

// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue
//   In-order writeback queue in front of the register file's single write
//   port. Accepts up to two results per cycle (load first, then ALU), drains
//   one entry per cycle unless rf_hold is high, and reports pending writes
//   to the operand-read stage.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   wb       : regfile_writeback_queue_if.slave (sources, write port,
//              scoreboard queries, occupancy)
// Configuration macro:
//   WB_FORWARD_EN : when defined, fwd_data_a/b carry the youngest matching
//                   queued data; otherwise they are tied to zero.
module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  regfile_writeback_queue_if.slave wb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] alu_slot;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] free;
  logic             ld_rdy, alu_rdy;
  logic             ld_store, alu_store, drain;
  logic             hit_a, hit_b;
  logic [DATA_W-1:0] fwd_a, fwd_b;
  logic [PTR_W-1:0] idx;

  // Readiness looks only at registered occupancy; a same-cycle drain
  // never frees a slot early.
  always_comb begin
    free    = DEPTH_C - count_q;
    ld_rdy  = (free != '0);
    alu_rdy = (free >= CNT_W'(2)) || ((free != '0) && !wb.ld_valid);
  end

  // Writes to x0 complete the handshake but are dropped.
  always_comb begin
    ld_store  = wb.ld_valid  && ld_rdy  && (wb.ld_addr  != '0);
    alu_store = wb.alu_valid && alu_rdy && (wb.alu_addr != '0);
    drain     = (count_q != '0) && !wb.rf_hold;
    alu_slot  = tail_q + PTR_W'(ld_store);
    tail_d    = tail_q + PTR_W'(ld_store) + PTR_W'(alu_store);
    head_d    = head_q + PTR_W'(drain);
    count_d   = count_q + CNT_W'(ld_store) + CNT_W'(alu_store) - CNT_W'(drain);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (ld_store)  mem_q[tail_q]   <= '{addr: wb.ld_addr,  data: wb.ld_data};
    if (alu_store) mem_q[alu_slot] <= '{addr: wb.alu_addr, data: wb.alu_data};
  end

  // Walk oldest to youngest so the last match is the youngest entry.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    fwd_a = '0;
    fwd_b = '0;
    idx   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if (k < 32'(count_q)) begin
        if ((wb.query_addr_a != '0) && (mem_q[idx].addr == wb.query_addr_a)) begin
          hit_a = 1'b1;
`ifdef WB_FORWARD_EN
          fwd_a = mem_q[idx].data;
`endif
        end
        if ((wb.query_addr_b != '0) && (mem_q[idx].addr == wb.query_addr_b)) begin
          hit_b = 1'b1;
`ifdef WB_FORWARD_EN
          fwd_b = mem_q[idx].data;
`endif
        end
      end
    end
  end

  assign wb.ld_ready      = ld_rdy;
  assign wb.alu_ready     = alu_rdy;
  assign wb.rf_write_en   = drain;
  // Head fields are masked when empty so the write port reads zero after reset.
  assign wb.rf_write_addr = (count_q != '0) ? mem_q[head_q].addr : '0;
  assign wb.rf_write_data = (count_q != '0) ? mem_q[head_q].data : '0;
  assign wb.pend_hit_a    = hit_a;
  assign wb.pend_hit_b    = hit_b;
  assign wb.fwd_data_a    = fwd_a;
  assign wb.fwd_data_b    = fwd_b;
  assign wb.wb_count      = count_q;
endmodule

// File: tb/tb_regfile_writeback_queue.sv
module tb_regfile_writeback_queue;
  logic clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  regfile_writeback_queue_if #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) wbif ();

  regfile_writeback_queue #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wb      (wbif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wbif.ld_valid  = 1'b0;
    wbif.alu_valid = 1'b0;
    wbif.ld_addr   = '0;
    wbif.alu_addr  = '0;
    wbif.ld_data   = '0;
    wbif.alu_data  = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    wbif.rf_hold      = 1'b0;
    wbif.query_addr_a = '0;
    wbif.query_addr_b = '0;
    #12;
    chk("rst_count", 32'(wbif.wb_count), 0);
    chk("rst_we", 32'(wbif.rf_write_en), 0);
    chk("rst_waddr", 32'(wbif.rf_write_addr), 0);
    chk("rst_ld_ready", 32'(wbif.ld_ready), 1);
    chk("rst_alu_ready", 32'(wbif.alu_ready), 1);
    reset_n = 1'b1;
    step();

    // single ALU write, one-cycle latency
    wbif.alu_valid = 1'b1; wbif.alu_addr = 5'd5; wbif.alu_data = 32'hDEADBEEF;
    chk("t1_alu_ready", 32'(wbif.alu_ready), 1);
    step();
    idle();
    chk("t1_count1", 32'(wbif.wb_count), 1);
    chk("t1_we", 32'(wbif.rf_write_en), 1);
    chk("t1_addr", 32'(wbif.rf_write_addr), 5);
    chk("t1_data", wbif.rf_write_data, 32'hDEADBEEF);
    step();
    chk("t1_count0", 32'(wbif.wb_count), 0);
    chk("t1_we_off", 32'(wbif.rf_write_en), 0);

    // dual enqueue: load is older
    wbif.ld_valid = 1'b1;  wbif.ld_addr = 5'd3;  wbif.ld_data = 32'h11;
    wbif.alu_valid = 1'b1; wbif.alu_addr = 5'd4; wbif.alu_data = 32'h22;
    chk("t2_ld_ready", 32'(wbif.ld_ready), 1);
    chk("t2_alu_ready", 32'(wbif.alu_ready), 1);
    step();
    idle();
    chk("t2_count2", 32'(wbif.wb_count), 2);
    chk("t2_addr0", 32'(wbif.rf_write_addr), 3);
    chk("t2_data0", wbif.rf_write_data, 32'h11);
    step();
    chk("t2_count1", 32'(wbif.wb_count), 1);
    chk("t2_addr1", 32'(wbif.rf_write_addr), 4);
    chk("t2_data1", wbif.rf_write_data, 32'h22);
    step();
    chk("t2_count0", 32'(wbif.wb_count), 0);

    // fill under hold, alternating sources
    wbif.rf_hold = 1'b1;
    wbif.ld_valid = 1'b1; wbif.ld_addr = 5'd1; wbif.ld_data = 32'h101;
    step(); idle();
    wbif.alu_valid = 1'b1; wbif.alu_addr = 5'd2; wbif.alu_data = 32'h102;
    step(); idle();
    wbif.ld_valid = 1'b1; wbif.ld_addr = 5'd6; wbif.ld_data = 32'h103;
    step(); idle();
    chk("t3_count3", 32'(wbif.wb_count), 3);
    chk("t3_hold_we", 32'(wbif.rf_write_en), 0);
    chk("t3_hold_head", 32'(wbif.rf_write_addr), 1);
    wbif.ld_valid = 1'b1;  wbif.ld_addr = 5'd8;  wbif.ld_data = 32'h104;
    wbif.alu_valid = 1'b1; wbif.alu_addr = 5'd9; wbif.alu_data = 32'h105;
    chk("t3_ld_ready_c3", 32'(wbif.ld_ready), 1);
    chk("t3_alu_ready_c3", 32'(wbif.alu_ready), 0);
    step(); idle();
    chk("t3_count4", 32'(wbif.wb_count), 4);
    chk("t3_ld_ready_full", 32'(wbif.ld_ready), 0);
    chk("t3_alu_ready_full", 32'(wbif.alu_ready), 0);
    wbif.query_addr_a = 5'd6; wbif.query_addr_b = 5'd9;
    #1;
    chk("t3_hit_x6", 32'(wbif.pend_hit_a), 1);
    chk("t3_miss_x9", 32'(wbif.pend_hit_b), 0);
    wbif.query_addr_a = '0; wbif.query_addr_b = '0;
    wbif.rf_hold = 1'b0;
    #1;
    chk("t3_w0_we", 32'(wbif.rf_write_en), 1);
    chk("t3_w0_addr", 32'(wbif.rf_write_addr), 1);
    chk("t3_w0_data", wbif.rf_write_data, 32'h101);
    step();
    chk("t3_w1_addr", 32'(wbif.rf_write_addr), 2);
    chk("t3_w1_data", wbif.rf_write_data, 32'h102);
    step();
    chk("t3_w2_addr", 32'(wbif.rf_write_addr), 6);
    chk("t3_w2_data", wbif.rf_write_data, 32'h103);
    step();
    chk("t3_w3_we", 32'(wbif.rf_write_en), 1);
    chk("t3_w3_addr", 32'(wbif.rf_write_addr), 8);
    chk("t3_w3_data", wbif.rf_write_data, 32'h104);
    step();
    chk("t3_drained", 32'(wbif.wb_count), 0);
    chk("t3_drained_we", 32'(wbif.rf_write_en), 0);

    // x0 destination is accepted but dropped
    wbif.alu_valid = 1'b1; wbif.alu_addr = 5'd0; wbif.alu_data = 32'hFFFFFFFF;
    chk("t4_alu_ready", 32'(wbif.alu_ready), 1);
    step(); idle();
    chk("t4_count", 32'(wbif.wb_count), 0);
    chk("t4_we", 32'(wbif.rf_write_en), 0);
    chk("t4_hit_x0", 32'(wbif.pend_hit_a), 0);

    // same-address entries: youngest forwards
    wbif.rf_hold = 1'b1;
    wbif.alu_valid = 1'b1; wbif.alu_addr = 5'd7; wbif.alu_data = 32'hA;
    step(); idle();
    wbif.ld_valid = 1'b1; wbif.ld_addr = 5'd7; wbif.ld_data = 32'hB;
    step(); idle();
    wbif.query_addr_a = 5'd7; wbif.query_addr_b = 5'd5;
    #1;
    chk("t5_count", 32'(wbif.wb_count), 2);
    chk("t5_hit_a", 32'(wbif.pend_hit_a), 1);
`ifdef WB_FORWARD_EN
    chk("t5_fwd_a", wbif.fwd_data_a, 32'hB);
`else
    chk("t5_fwd_a", wbif.fwd_data_a, 32'h0);
`endif
    chk("t5_hit_b", 32'(wbif.pend_hit_b), 0);
    chk("t5_fwd_b", wbif.fwd_data_b, 32'h0);

    // asynchronous reset with three entries queued
    wbif.ld_valid = 1'b1; wbif.ld_addr = 5'd10; wbif.ld_data = 32'hC;
    step(); idle();
    chk("t6_count3", 32'(wbif.wb_count), 3);
    wbif.rf_hold = 1'b0;
    #1;
    chk("t6_pre_we", 32'(wbif.rf_write_en), 1);
    chk("t6_pre_data", wbif.rf_write_data, 32'hA);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_we", 32'(wbif.rf_write_en), 0);
    chk("t6_rst_count", 32'(wbif.wb_count), 0);
    chk("t6_rst_hit", 32'(wbif.pend_hit_a), 0);
    reset_n = 1'b1;
    wbif.query_addr_a = '0; wbif.query_addr_b = '0;
    wbif.alu_valid = 1'b1; wbif.alu_addr = 5'd12; wbif.alu_data = 32'h55;
    step(); idle();
    chk("t6_new_count", 32'(wbif.wb_count), 1);
    chk("t6_new_we", 32'(wbif.rf_write_en), 1);
    chk("t6_new_addr", 32'(wbif.rf_write_addr), 12);
    chk("t6_new_data", wbif.rf_write_data, 32'h55);
    step();
    chk("t6_empty", 32'(wbif.wb_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
